audio_pll_reset_seq: RTL and testbench

- Sequences reset and lock acquisition for the audio PLL (50 MHz refclk in, 18.432 MHz audio master clock out).
- Pulses the PLL reset, then waits for lock with a timeout and a bounded number of retries.
- Requires lock to stay stable before releasing the audio-domain reset.
- Detects loss of lock in service and re-acquires. Sits between board reset and the PLL/audio-domain reset tree; runs entirely on refclk.

---
 rtl/audio_pll_reset_seq.sv | 150 +++++++++++++++
 tb/tb_audio_pll_reset_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_pll_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module   : audio_pll_reset_seq
//  Brief    : Audio PLL reset pulse, lock acquisition with timeout/retry,
//             lock-stability qualification and in-service lock-loss recovery.
//  Revision : 1.0  initial release
// ============================================================================
module audio_pll_reset_seq #(
    parameter int RST_PULSE_CYCLES    = 100,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int STABLE_CYCLES       = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       audio_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_count,
    output logic [7:0] lock_loss_cnt,
    output logic       lock_lost
);

    localparam logic [2:0] c_S_RESET_PLL = 3'd0;
    localparam logic [2:0] c_S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] c_S_STABLE    = 3'd2;
    localparam logic [2:0] c_S_RUN       = 3'd3;
    localparam logic [2:0] c_S_FAULT     = 3'd4;

    localparam logic [CNT_W-1:0] c_RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       c_MAX_RETRIES  = 2'(MAX_RETRIES);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_locked_s;
    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_retry;
    logic [1:0]       w_next_retry;
    logic [7:0]       r_loss;
    logic             r_lock_lost;
    logic             w_lock_lost;
    logic             w_cnt_run;

    // pll_locked is asynchronous to refclk
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_locked;
            r_sync2 <= r_sync1;
        end
    end

    assign w_locked_s = r_sync2;

    always_comb begin
        w_next_state = r_state;
        w_next_retry = r_retry;
        w_lock_lost  = 1'b0;
        case (r_state)
            c_S_RESET_PLL: begin
                if (r_cnt == c_RST_LAST) begin
                    w_next_state = c_S_WAIT_LOCK;
                end
            end
            c_S_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_next_state = c_S_STABLE;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    if (r_retry == c_MAX_RETRIES) begin
                        w_next_state = c_S_FAULT;
                    end else begin
                        w_next_retry = r_retry + 2'd1;
                        w_next_state = c_S_RESET_PLL;
                    end
                end
            end
            c_S_STABLE: begin
                // a drop here is a glitch: re-wait without consuming a retry
                if (!w_locked_s) begin
                    w_next_state = c_S_WAIT_LOCK;
                end else if (r_cnt == c_STABLE_LAST) begin
                    w_next_state = c_S_RUN;
                    w_next_retry = 2'd0;
                end
            end
            c_S_RUN: begin
                if (!w_locked_s) begin
                    w_lock_lost  = 1'b1;
                    w_next_state = c_S_RESET_PLL;
                end else if (relock_req) begin
                    w_next_state = c_S_RESET_PLL;
                end
            end
            c_S_FAULT: begin
                if (relock_req) begin
                    w_next_state = c_S_RESET_PLL;
                    w_next_retry = 2'd0;
                end
            end
            default: begin
                w_next_state = c_S_RESET_PLL;
            end
        endcase
    end

    assign w_cnt_run = (r_state == c_S_RESET_PLL) || (r_state == c_S_WAIT_LOCK) ||
                       (r_state == c_S_STABLE);

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state     <= c_S_RESET_PLL;
            r_cnt       <= '0;
            r_retry     <= 2'd0;
            r_loss      <= 8'd0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_retry     <= w_next_retry;
            r_lock_lost <= w_lock_lost;
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (w_cnt_run) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_lock_lost && (r_loss != 8'hFF)) begin
                r_loss <= r_loss + 8'd1;
            end
        end
    end

    assign pll_rst       = (r_state == c_S_RESET_PLL) || (r_state == c_S_FAULT);
    assign audio_rst     = (r_state != c_S_RUN);
    assign ready         = (r_state == c_S_RUN);
    assign fault         = (r_state == c_S_FAULT);
    assign retry_count   = r_retry;
    assign lock_loss_cnt = r_loss;
    assign lock_lost     = r_lock_lost;

endmodule
`default_nettype wire

// File: tb/tb_audio_pll_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_audio_pll_reset_seq
//  Brief    : Scoreboard bench for audio_pll_reset_seq against a behavioural
//             phase/countdown model of the acquisition rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_audio_pll_reset_seq;

    localparam int P_RST  = 4;
    localparam int P_TO   = 20;
    localparam int P_ST   = 8;
    localparam int P_MAXR = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       audio_rst;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;
    logic [7:0] lock_loss_cnt;
    logic       lock_lost;

    always #5 refclk = ~refclk;

    audio_pll_reset_seq #(
        .RST_PULSE_CYCLES    (P_RST),
        .LOCK_TIMEOUT_CYCLES (P_TO),
        .STABLE_CYCLES       (P_ST),
        .MAX_RETRIES         (P_MAXR),
        .CNT_W               (8)
    ) u_dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .relock_req    (relock_req),
        .pll_rst       (pll_rst),
        .audio_rst     (audio_rst),
        .ready         (ready),
        .fault         (fault),
        .retry_count   (retry_count),
        .lock_loss_cnt (lock_loss_cnt),
        .lock_lost     (lock_lost)
    );

    typedef struct packed {
        logic       pll_rst;
        logic       audio_rst;
        logic       ready;
        logic       fault;
        logic [1:0] retry;
        logic [7:0] loss;
        logic       lost;
    } exp_t;

    typedef enum int {PH_RST, PH_WAIT, PH_STAB, PH_RUN, PH_FLT} phase_t;

    exp_t   exp_q[$];
    exp_t   m_e;
    int     n_checks = 0;
    int     n_pass   = 0;

    // reference model: phase plus remaining-cycle countdown
    phase_t m_phase   = PH_RST;
    int     m_left    = P_RST;
    int     m_retries = 0;
    int     m_losses  = 0;
    bit     m_lost    = 1'b0;
    bit     m_dl[$]   = '{1'b0, 1'b0};

    task automatic model_step(input bit r, input bit rq, input bit pl);
        bit ls;
        ls     = m_dl[0];
        m_lost = 1'b0;
        if (r) begin
            m_phase   = PH_RST;
            m_left    = P_RST;
            m_retries = 0;
            m_losses  = 0;
            m_dl      = '{1'b0, 1'b0};
        end else begin
            case (m_phase)
                PH_RST: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = PH_WAIT; m_left = P_TO; end
                end
                PH_WAIT: begin
                    if (ls) begin
                        m_phase = PH_STAB; m_left = P_ST;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            if (m_retries == P_MAXR) m_phase = PH_FLT;
                            else begin m_retries++; m_phase = PH_RST; m_left = P_RST; end
                        end
                    end
                end
                PH_STAB: begin
                    if (!ls) begin
                        m_phase = PH_WAIT; m_left = P_TO;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin m_phase = PH_RUN; m_retries = 0; end
                    end
                end
                PH_RUN: begin
                    if (!ls) begin
                        m_lost = 1'b1;
                        if (m_losses < 255) m_losses++;
                        m_phase = PH_RST; m_left = P_RST;
                    end else if (rq) begin
                        m_phase = PH_RST; m_left = P_RST;
                    end
                end
                PH_FLT: begin
                    if (rq) begin m_phase = PH_RST; m_left = P_RST; m_retries = 0; end
                end
                default: ;
            endcase
            m_dl.push_back(pl);
            void'(m_dl.pop_front());
        end
    endtask

    function automatic exp_t expected();
        exp_t e;
        e.pll_rst   = (m_phase == PH_RST) || (m_phase == PH_FLT);
        e.audio_rst = (m_phase != PH_RUN);
        e.ready     = (m_phase == PH_RUN);
        e.fault     = (m_phase == PH_FLT);
        e.retry     = 2'(m_retries);
        e.loss      = 8'(m_losses);
        e.lost      = m_lost;
        return e;
    endfunction

    task automatic tick();
        @(posedge refclk);
        model_step(rst, relock_req, pll_locked);
        exp_q.push_back(expected());
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    endtask

    task automatic wait_phase(input phase_t p, input int budget, input string nm);
        int k;
        k = 0;
        while (m_phase != p && k < budget) begin
            tick();
            k++;
        end
        if (m_phase != p) begin
            n_checks++;
            $display("FAIL %s: target phase %0d not reached in %0d cycles (at %0d)",
                     nm, p, budget, m_phase);
        end
    endtask

    task automatic pulse_relock();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
    endtask

    // monitor: one expected record per clock edge
    initial begin
        forever begin
            @(negedge refclk);
            if (exp_q.size() > 0) begin
                m_e = exp_q.pop_front();
                chk("pll_rst",       {7'd0, pll_rst},   {7'd0, m_e.pll_rst});
                chk("audio_rst",     {7'd0, audio_rst}, {7'd0, m_e.audio_rst});
                chk("ready",         {7'd0, ready},     {7'd0, m_e.ready});
                chk("fault",         {7'd0, fault},     {7'd0, m_e.fault});
                chk("retry_count",   {6'd0, retry_count}, {6'd0, m_e.retry});
                chk("lock_loss_cnt", lock_loss_cnt,     m_e.loss);
                chk("lock_lost",     {7'd0, lock_lost}, {7'd0, m_e.lost});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; relock_req = 1'b0; pll_locked = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // normal bring-up, lock 5 cycles after pll_rst falls
        wait_phase(PH_WAIT, 10, "bringup_wait");
        repeat (4) tick();
        pll_locked = 1'b1;
        wait_phase(PH_RUN, 40, "bringup_run");
        repeat (5) tick();

        // timeouts into fault, then recovery
        pll_locked = 1'b0;
        pulse_relock();
        wait_phase(PH_FLT, 120, "to_fault");
        repeat (10) tick();
        pulse_relock();
        pll_locked = 1'b1;
        wait_phase(PH_RUN, 60, "recover_run");

        // one-cycle glitch three cycles into STABLE
        pulse_relock();
        wait_phase(PH_STAB, 40, "glitch_stab");
        repeat (3) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        wait_phase(PH_RUN, 80, "glitch_run");

        // rst asserted during STABLE
        pulse_relock();
        wait_phase(PH_STAB, 40, "rst_stab");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_phase(PH_RUN, 60, "rst_run");

        // relock_req coincident with locked_s falling
        repeat (2) tick();
        pll_locked = 1'b0;
        repeat (2) tick();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        pll_locked = 1'b1;
        wait_phase(PH_RUN, 60, "simul_run");

        // 300 in-service losses to saturate the loss counter
        for (int i = 0; i < 300; i++) begin
            wait_phase(PH_RUN, 60, "loss_run");
            repeat ($urandom_range(0, 3)) tick();
            pll_locked = 1'b0;
            tick();
            pll_locked = 1'b1;
        end
        wait_phase(PH_RUN, 60, "loss_final");

        // randomized mix of events
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: begin
                    pll_locked = 1'b0;
                    repeat ($urandom_range(1, 4)) tick();
                    pll_locked = 1'b1;
                end
                1: pulse_relock();
                2: begin
                    rst = 1'b1;
                    repeat ($urandom_range(1, 2)) tick();
                    rst = 1'b0;
                end
                3: begin
                    pll_locked = 1'b0;
                    repeat ($urandom_range(0, 80)) tick();
                    if ($urandom_range(0, 1) == 1) pulse_relock();
                    pll_locked = 1'b1;
                end
                default: begin
                    relock_req = 1'($urandom_range(0, 1));
                    tick();
                    relock_req = 1'b0;
                end
            endcase
            repeat ($urandom_range(0, 30)) tick();
        end

        pll_locked = 1'b1;
        if (m_phase == PH_FLT) pulse_relock();
        wait_phase(PH_RUN, 80, "final_run");
        repeat (3) tick();
        @(negedge refclk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
